burst_master_port: RTL and testbench

Parametrised next-generation serial bus master port. It sits between a master device and the serial system bus, arbiter and address decoder. It accepts burst commands of 1..2^BURST_WIDTH words and runs each beat as a complete serial transaction (slave ID, ack, memory address, data) while holding bus ownership. It adds auto-increment addressing, per-beat write-data and read-data handshakes, and timeout-based error abort.

---
 rtl/burst_master_port.sv | 182 ++++++++++++++++++
 tb/tb_burst_master_port.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_master_port.sv
// burst_master_port: turns burst commands into back-to-back serial bus transactions,
// one complete slave-ID/ack/address/data transaction per beat while holding the bus.
module burst_master_port #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int SLAVE_ID_WIDTH = 4,
    parameter int BURST_WIDTH    = 4,
    parameter int TIMEOUT        = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   dvalid,
    output logic                   dready,
    input  logic [ADDR_WIDTH-1:0]  daddr,
    input  logic                   dmode,
    input  logic [BURST_WIDTH-1:0] dlen,
    input  logic [DATA_WIDTH-1:0]  dwdata,
    input  logic                   dwvalid,
    output logic                   dwready,
    output logic [DATA_WIDTH-1:0]  drdata,
    output logic                   drvalid,
    output logic                   ddone,
    output logic                   derr,
    output logic                   mwdata,
    output logic                   mvalid,
    output logic                   mmode,
    input  logic                   mrdata,
    input  logic                   svalid,
    output logic                   mbreq,
    input  logic                   mbgrant,
    input  logic                   ack
);
    localparam int MEM_W = ADDR_WIDTH - SLAVE_ID_WIDTH;
    localparam int SW0   = MEM_W > DATA_WIDTH ? MEM_W : DATA_WIDTH;
    localparam int SW    = SW0 > SLAVE_ID_WIDTH ? SW0 : SLAVE_ID_WIDTH;
    localparam int BCW   = $clog2(SW + 1);
    localparam int ICW   = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {IDLE, REQ, SADDR, WAIT, ADDR, WDATA, RDATA, BEAT, WNEXT, ERR} state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   mode_q;
    logic [BURST_WIDTH-1:0] beat_q;
    logic [DATA_WIDTH-1:0]  wdata_q, rdata_q, drdata_q;
    logic [SW-1:0]          sh_q;
    logic [BCW-1:0]         bcnt_q;
    logic [ICW-1:0]         idle_q;
    logic                   mwdata_q, mvalid_q, drvalid_q, ddone_q, derr_q;
    logic [DATA_WIDTH-1:0]  rdata_d;

    assign rdata_d = {mrdata, rdata_q[DATA_WIDTH-1:1]};
    assign dready  = state_q == IDLE;
    assign mbreq   = state_q != IDLE;
    assign dwready = state_q == WNEXT;
    assign mmode   = mode_q;
    assign mwdata  = mwdata_q;
    assign mvalid  = mvalid_q;
    assign drdata  = drdata_q;
    assign drvalid = drvalid_q;
    assign ddone   = ddone_q;
    assign derr    = derr_q;

    // Serial fields are preloaded into sh_q on state entry and shifted out LSB first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            mode_q    <= 1'b0;
            beat_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            drdata_q  <= '0;
            sh_q      <= '0;
            bcnt_q    <= '0;
            idle_q    <= '0;
            mwdata_q  <= 1'b0;
            mvalid_q  <= 1'b0;
            drvalid_q <= 1'b0;
            ddone_q   <= 1'b0;
            derr_q    <= 1'b0;
        end else begin
            mwdata_q  <= 1'b0;
            mvalid_q  <= 1'b0;
            drvalid_q <= 1'b0;
            ddone_q   <= 1'b0;
            derr_q    <= 1'b0;
            case (state_q)
                IDLE: if (dvalid) begin
                    addr_q  <= daddr;
                    mode_q  <= dmode;
                    beat_q  <= dlen;
                    wdata_q <= dwdata;
                    state_q <= REQ;
                end
                REQ: if (mbgrant) begin
                    sh_q    <= SW'(addr_q[ADDR_WIDTH-1:MEM_W]);
                    bcnt_q  <= '0;
                    state_q <= SADDR;
                end
                SADDR: begin
                    mvalid_q <= 1'b1;
                    mwdata_q <= sh_q[0];
                    sh_q     <= sh_q >> 1;
                    bcnt_q   <= bcnt_q + BCW'(1);
                    if (bcnt_q == BCW'(SLAVE_ID_WIDTH - 1)) begin
                        bcnt_q  <= '0;
                        idle_q  <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: if (ack) begin
                    sh_q    <= SW'(addr_q[MEM_W-1:0]);
                    state_q <= ADDR;
                end else if (idle_q == ICW'(TIMEOUT - 1)) begin
                    derr_q  <= 1'b1;
                    state_q <= ERR;
                end else begin
                    idle_q <= idle_q + ICW'(1);
                end
                ADDR: begin
                    mvalid_q <= 1'b1;
                    mwdata_q <= sh_q[0];
                    sh_q     <= sh_q >> 1;
                    bcnt_q   <= bcnt_q + BCW'(1);
                    if (bcnt_q == BCW'(MEM_W - 1)) begin
                        bcnt_q  <= '0;
                        idle_q  <= '0;
                        sh_q    <= SW'(wdata_q);
                        state_q <= mode_q ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    mvalid_q <= 1'b1;
                    mwdata_q <= sh_q[0];
                    sh_q     <= sh_q >> 1;
                    bcnt_q   <= bcnt_q + BCW'(1);
                    if (bcnt_q == BCW'(DATA_WIDTH - 1)) begin
                        bcnt_q  <= '0;
                        ddone_q <= beat_q == '0;
                        state_q <= BEAT;
                    end
                end
                RDATA: if (svalid) begin
                    rdata_q <= rdata_d;
                    idle_q  <= '0;
                    bcnt_q  <= bcnt_q + BCW'(1);
                    if (bcnt_q == BCW'(DATA_WIDTH - 1)) begin
                        bcnt_q    <= '0;
                        drdata_q  <= rdata_d;
                        drvalid_q <= 1'b1;
                        ddone_q   <= beat_q == '0;
                        state_q   <= BEAT;
                    end
                end else if (idle_q == ICW'(TIMEOUT - 1)) begin
                    derr_q  <= 1'b1;
                    state_q <= ERR;
                end else begin
                    idle_q <= idle_q + ICW'(1);
                end
                // Only the memory field advances; the slave ID is fixed for the burst.
                BEAT: if (beat_q == '0) begin
                    state_q <= IDLE;
                end else begin
                    beat_q             <= beat_q - BURST_WIDTH'(1);
                    addr_q[MEM_W-1:0]  <= addr_q[MEM_W-1:0] + MEM_W'(1);
                    sh_q               <= SW'(addr_q[ADDR_WIDTH-1:MEM_W]);
                    bcnt_q             <= '0;
                    state_q            <= mode_q ? WNEXT : SADDR;
                end
                WNEXT: if (dwvalid) begin
                    wdata_q <= dwdata;
                    sh_q    <= SW'(addr_q[ADDR_WIDTH-1:MEM_W]);
                    bcnt_q  <= '0;
                    state_q <= SADDR;
                end
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_master_port.sv
// tb_burst_master_port: directed bursts against a queue model of the expected
// serial bit stream, read words and completion/error pulses.
module tb_burst_master_port;
    localparam int T = 16;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        dvalid = 1'b0, dmode = 1'b0, dwvalid = 1'b0;
    logic [15:0] daddr = '0;
    logic [3:0]  dlen = '0;
    logic [7:0]  dwdata = '0;
    logic        mrdata = 1'b0, svalid = 1'b0, mbgrant = 1'b0, ack = 1'b0;
    logic        dready, dwready, drvalid, ddone, derr, mwdata, mvalid, mmode, mbreq;
    logic [7:0]  drdata;

    burst_master_port #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .SLAVE_ID_WIDTH(4),
                        .BURST_WIDTH(4), .TIMEOUT(T)) dut (
        .clk(clk), .rstn(rstn), .dvalid(dvalid), .dready(dready), .daddr(daddr),
        .dmode(dmode), .dlen(dlen), .dwdata(dwdata), .dwvalid(dwvalid), .dwready(dwready),
        .drdata(drdata), .drvalid(drvalid), .ddone(ddone), .derr(derr), .mwdata(mwdata),
        .mvalid(mvalid), .mmode(mmode), .mrdata(mrdata), .svalid(svalid), .mbreq(mbreq),
        .mbgrant(mbgrant), .ack(ack)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int ddone_n = 0, derr_n = 0, drv_n = 0, idle_n = 0;
    int e_done = 0, e_err = 0, e_rv = 0;
    int gcnt = 0;
    bit         exp_bits[$];
    logic [7:0] exp_rd[$];
    logic [7:0] words[0:15];
    logic       cur_mode = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] beat_addr(input logic [15:0] a, input int b);
        return {a[15:12], 12'(int'(a[11:0]) + b)};
    endfunction

    task automatic push_burst(input logic [15:0] a, input logic m, input int l);
        for (int b = 0; b <= l; b++) begin
            logic [15:0] ba;
            ba = beat_addr(a, b);
            for (int i = 0; i < 4; i++) exp_bits.push_back(ba[12+i]);
            for (int i = 0; i < 12; i++) exp_bits.push_back(ba[i]);
            if (m) for (int i = 0; i < 8; i++) exp_bits.push_back(words[b][i]);
            else exp_rd.push_back(words[b]);
        end
    endtask

    // Arbiter: grant after the request has been seen for two cycles.
    initial forever begin
        @(negedge clk);
        gcnt = mbreq ? gcnt + 1 : 0;
        mbgrant = gcnt >= 2;
    end

    initial forever begin
        @(negedge clk);
        if (rstn) begin
            chk("dready_vs_mbreq", dready, !mbreq);
            if (!mbreq) idle_n++;
            if (mbreq) chk("mmode", mmode, cur_mode);
            if (mvalid) begin
                if (exp_bits.size() == 0) chk("extra_bit", 1, 0);
                else chk("serial_bit", mwdata, exp_bits.pop_front());
            end
            if (drvalid) begin
                drv_n++;
                if (exp_rd.size() == 0) chk("extra_rd", 1, 0);
                else chk("drdata", drdata, exp_rd.pop_front());
            end
            if (ddone) ddone_n++;
            if (derr) derr_n++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_bits(input int n);
        int c = 0, k = 0;
        while (c < n && k < 400) begin
            @(negedge clk);
            k++;
            if (mvalid) c++;
        end
        if (c < n) chk("bit_wait_timeout", c, n);
    endtask

    task automatic cmd(input logic [15:0] a, input logic m, input int l);
        chk("dready_idle", dready, 1);
        push_burst(a, m, l);
        cur_mode = m;
        dvalid = 1'b1; daddr = a; dmode = m; dlen = 4'(l); dwdata = words[0];
        @(negedge clk);
        dvalid = 1'b0; daddr = 16'hBEEF; dwdata = 8'h00;
        chk("dready_busy", dready, 0);
    endtask

    task automatic do_ack(input int d);
        wait_bits(4);
        if (d >= 0) begin
            repeat (d) @(negedge clk);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
        end
    endtask

    task automatic read_word(input logic [7:0] w, input int gap, input int nb);
        for (int i = 0; i < nb; i++) begin
            svalid = 1'b1; mrdata = w[i];
            @(negedge clk);
            svalid = 1'b0; mrdata = 1'b0;
            if (i < nb - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_derr(input int exp_n);
        int n = 0;
        while (!derr && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("derr_latency", n, exp_n);
    endtask

    task automatic tally();
        chk("ddone_count", ddone_n, e_done);
        chk("derr_count", derr_n, e_err);
        chk("drvalid_count", drv_n, e_rv);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) words[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_dready", dready, 1);
        chk("rst_mbreq", mbreq, 0);
        chk("rst_mvalid", mvalid, 0);
        chk("rst_outs", {drvalid, ddone, derr, dwready, mmode}, 0);
        chk("rst_drdata", drdata, 0);
        rstn = 1'b1;
        @(negedge clk);

        // single write
        words[0] = 8'hA7;
        cmd(16'h3A5C, 1'b1, 0);
        chk("model_id_bits", {exp_bits[3], exp_bits[2], exp_bits[1], exp_bits[0]}, 4'b0011);
        chk("model_len", exp_bits.size(), 24);
        do_ack(3);
        wait_bits(20);
        chk("t1_ddone", ddone, 1);
        chk("t1_drvalid", drvalid, 0);
        @(negedge clk);
        chk("t1_mbreq_low", mbreq, 0);
        e_done++;
        tally();

        // read burst across the memory-field wrap
        begin
            int snap;
            words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
            chk("model_wrap", beat_addr(16'h2FFE, 2), 16'h2000);
            cmd(16'h2FFE, 1'b0, 2);
            snap = idle_n;
            for (int b = 0; b < 3; b++) begin
                do_ack(1);
                wait_bits(12);
                read_word(words[b], 3, 8);
                chk("t2_drvalid", drvalid, 1);
                chk("t2_ddone", ddone, b == 2);
            end
            chk("t2_mbreq_held", idle_n, snap);
            e_done++; e_rv += 3;
            @(negedge clk);
            tally();
        end

        // write burst with a stalled second word; dwvalid outside WNEXT is noise
        words[0] = 8'h3C; words[1] = 8'hC5;
        cmd(16'h5123, 1'b1, 1);
        dwvalid = 1'b1; dwdata = 8'hFF;
        do_ack(2);
        wait_bits(20);
        dwvalid = 1'b0; dwdata = 8'h00;
        chk("t3_ddone_first", ddone, 0);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk("t3_dwready_hold", dwready, 1);
            if (k == 9) begin dwvalid = 1'b1; dwdata = words[1]; end
            @(negedge clk);
        end
        dwvalid = 1'b0;
        chk("t3_dwready_drop", dwready, 0);
        do_ack(0);
        wait_bits(20);
        chk("t3_ddone", ddone, 1);
        e_done++;
        @(negedge clk);
        tally();

        // ack never arrives
        words[0] = 8'h00;
        cmd(16'h7001, 1'b0, 0);
        do_ack(-1);
        wait_derr(T);
        chk("t4_leftover_bits", exp_bits.size(), 12);
        exp_bits.delete(); exp_rd.delete();
        @(negedge clk);
        chk("t4_mbreq_low", mbreq, 0);
        chk("t4_dready", dready, 1);
        e_err++;
        tally();

        // ack on the last allowed cycle
        words[0] = 8'h5A;
        cmd(16'h7001, 1'b0, 0);
        do_ack(T - 1);
        wait_bits(12);
        read_word(words[0], 1, 8);
        chk("t4b_drvalid", drvalid, 1);
        chk("t4b_ddone", ddone, 1);
        e_done++; e_rv++;
        @(negedge clk);
        tally();

        // read data stalls after five bits
        words[0] = 8'hC3;
        cmd(16'h1234, 1'b0, 0);
        do_ack(0);
        wait_bits(12);
        read_word(words[0], 3, 5);
        wait_derr(T);
        chk("t5_leftover_rd", exp_rd.size(), 1);
        exp_bits.delete(); exp_rd.delete();
        @(negedge clk);
        chk("t5_dready", dready, 1);
        e_err++;
        tally();

        // asynchronous reset in the middle of write data
        words[0] = 8'hFF;
        cmd(16'hF0F0, 1'b1, 0);
        do_ack(0);
        wait_bits(15);
        chk("t6_pre", {mvalid, mwdata}, 2'b11);
        #2 rstn = 1'b0;
        #1;
        chk("t6_mbreq", mbreq, 0);
        chk("t6_mvalid", mvalid, 0);
        chk("t6_mwdata", mwdata, 0);
        exp_bits.delete(); exp_rd.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        chk("t6_dready", dready, 1);
        chk("t6_pulses", {ddone, derr, drvalid}, 0);
        words[0] = 8'h96;
        cmd(16'h4321, 1'b0, 0);
        do_ack(2);
        wait_bits(12);
        read_word(words[0], 2, 8);
        chk("t6_drvalid", drvalid, 1);
        chk("t6_ddone", ddone, 1);
        e_done++; e_rv++;
        @(negedge clk);
        tally();
        chk("end_queue_empty", exp_bits.size() + exp_rd.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
